// File: rtl/im_loader_pkg.sv
// im_loader_pkg -- shared definitions for the serial instruction-memory loader.
//   SYNC_BYTE     : frame start marker
//   IM_AWIDTH_DEF : default instruction-memory word-address width
//   state_e       : loader FSM states
package im_loader_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         IM_AWIDTH_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/im_loader_if.sv
// im_loader_if -- byte stream in, instruction-memory write port out.
//   rx_data/rx_valid/rx_ready : byte handshake (transfer on valid && ready)
//   im_we/im_addr/im_wdata    : one-cycle word write strobe into instruction memory
//   modport master : byte source / memory side
//   modport slave  : the loader
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int IM_AWIDTH = IM_AWIDTH_DEF
);

  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 im_we;
  logic [IM_AWIDTH-1:0] im_addr;
  logic [31:0]          im_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/im_loader_timeout.sv
// loader_timeout -- counts consecutive idle cycles while enabled.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the idle count (a byte was transferred)
//   enable   : counting window is open (loader is inside a frame)
//   expired  : this cycle is the TIMEOUT_CYC-th consecutive idle cycle
module loader_timeout
  import im_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_reg;

  // cnt_reg holds the number of idle cycles already completed, so the
  // current idle cycle is the last allowed one when it equals LIMIT.
  assign expired = enable && !clear && (cnt_reg == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt_reg <= '0;
    end else if (!expired) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/im_loader.sv
// im_loader -- receives a framed byte stream and writes it into instruction memory.
// Frame: SYNC_BYTE, word count N (0 = full memory), 4N little-endian payload
// bytes, then the XOR of all payload bytes.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : byte handshake in, instruction-memory write port out
//   cpu_hold  : keeps the CPU in reset while a frame is in progress or failed
//   done      : last frame loaded with a good checksum
//   error     : last frame failed on checksum or timeout
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_AWIDTH   = IM_AWIDTH_DEF,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  im_loader_if.slave bus,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

  // Word counter must hold both 2^IM_AWIDTH and any 8-bit count byte.
  localparam int CNT_W = (IM_AWIDTH + 1 > 8) ? IM_AWIDTH + 1 : 8;
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(1) << IM_AWIDTH;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [IM_AWIDTH-1:0] IDX_ONE  = IM_AWIDTH'(1);
  localparam logic [IM_AWIDTH-1:0] IDX_LAST = '1;

  state_e               state_reg;
  logic [CNT_W-1:0]     word_cnt_reg;
  logic [IM_AWIDTH-1:0] word_idx_reg;
  logic [1:0]           byte_idx_reg;
  logic [7:0]           csum_reg;
  logic                 im_we_reg;
  logic [IM_AWIDTH-1:0] im_addr_reg;
  logic [31:0]          im_wdata_reg;
  logic                 cpu_hold_reg;
  logic                 done_reg;
  logic                 error_reg;

  logic                 xfer;
  logic                 active;
  logic                 timeout_hit;
  logic [23:0]          word_asm;

  assign bus.rx_ready = ~rst;
  assign xfer         = bus.rx_valid & ~rst;
  assign active       = (state_reg == ST_COUNT) || (state_reg == ST_DATA) ||
                        (state_reg == ST_CHECK);

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (xfer),
    .enable (active),
    .expired(timeout_hit)
  );

  // Byte lanes 0..2 are captured as they arrive; lane 3 goes straight from
  // rx_data into the write word, so the write issues the cycle after byte 3.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic       lane_we;

      assign lane_we = xfer && (state_reg == ST_DATA) && (byte_idx_reg == 2'(gi));
      assign word_asm[8*gi +: 8] = lane_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (lane_we) begin
          lane_reg <= bus.rx_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      csum_reg     <= '0;
      im_we_reg    <= 1'b0;
      im_addr_reg  <= '0;
      im_wdata_reg <= '0;
      cpu_hold_reg <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      im_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (xfer && (bus.rx_data == SYNC_BYTE)) begin
            state_reg    <= ST_COUNT;
            cpu_hold_reg <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            csum_reg     <= '0;
            byte_idx_reg <= '0;
            word_idx_reg <= '0;
          end
        end

        ST_COUNT: begin
          if (timeout_hit) begin
            state_reg <= ST_ERR;
            error_reg <= 1'b1;
          end else if (xfer) begin
            word_cnt_reg <= (bus.rx_data == 8'd0) ? FULL_CNT : CNT_W'(bus.rx_data);
            state_reg    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (timeout_hit) begin
            state_reg <= ST_ERR;
            error_reg <= 1'b1;
          end else if (xfer) begin
            csum_reg     <= csum_reg ^ bus.rx_data;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              im_we_reg    <= 1'b1;
              im_addr_reg  <= word_idx_reg;
              im_wdata_reg <= {bus.rx_data, word_asm};
              // Saturate at the top address so the index can never wrap.
              if (word_idx_reg != IDX_LAST) begin
                word_idx_reg <= word_idx_reg + IDX_ONE;
              end
              word_cnt_reg <= word_cnt_reg - CNT_ONE;
              if (word_cnt_reg == CNT_ONE) begin
                state_reg <= ST_CHECK;
              end
            end
          end
        end

        ST_CHECK: begin
          if (timeout_hit) begin
            state_reg <= ST_ERR;
            error_reg <= 1'b1;
          end else if (xfer) begin
            if (bus.rx_data == csum_reg) begin
              state_reg    <= ST_DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end else begin
              state_reg <= ST_ERR;
              error_reg <= 1'b1;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.im_we    = im_we_reg;
  assign bus.im_addr  = im_addr_reg;
  assign bus.im_wdata = im_wdata_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign done         = done_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader -- directed frames with a write scoreboard for im_loader.
module tb_im_loader;

  localparam int AW = 7;
  localparam int TO = 40;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold;
  logic done;
  logic error;

  im_loader_if #(.IM_AWIDTH(AW)) bus ();

  im_loader #(
    .IM_AWIDTH  (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  wr_t        exp_q[$];
  int         errors   = 0;
  int         checks   = 0;
  int         wr_count = 0;
  int         base;
  logic [7:0] csum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Advance one clock and sample just after the edge; every write strobe the
  // DUT produces is matched against the scoreboard here.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.im_we !== 1'b0) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(bus.im_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.im_addr), 32'(e.addr));
        check("wr_data", bus.im_wdata, e.data);
      end
      $display("write addr=%0d data=0x%08h", bus.im_addr, bus.im_wdata);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    if (gap) tick();
  endtask

  task automatic frame_start(input logic [7:0] n, input bit gap);
    csum = 8'h00;
    send(8'hA5, gap);
    send(n, gap);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr, input bit gap);
    wr_t e;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        e.addr = addr;
        e.data = w;
        exp_q.push_back(e);
      end
      csum = csum ^ w[8*k +: 8];
      send(w[8*k +: 8], gap);
    end
  endtask

  task automatic basic_frame(input bit gap);
    frame_start(8'h01, gap);
    send_word(32'h1234_5678, 7'd0, gap);
    send(8'h08, gap);
  endtask

  initial begin
    logic [31:0] w;

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_im_we", 32'(bus.im_we), 32'd0);
    check("rst_im_addr", 32'(bus.im_addr), 32'd0);
    check("rst_im_wdata", bus.im_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    tick();
    check("run_rx_ready", 32'(bus.rx_ready), 32'd1);

    // Single word, good checksum.
    base = wr_count;
    frame_start(8'h01, 1'b0);
    check("s1_hold_in_frame", 32'(cpu_hold), 32'd1);
    send_word(32'h1234_5678, 7'd0, 1'b0);
    send(8'h08, 1'b0);
    check("s1_done", 32'(done), 32'd1);
    check("s1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("s1_error", 32'(error), 32'd0);
    check("s1_writes", 32'(wr_count - base), 32'd1);

    // Two words (one containing sync bytes as data), wrong checksum.
    base = wr_count;
    frame_start(8'h02, 1'b0);
    check("s2_done_cleared", 32'(done), 32'd0);
    send_word(32'hDEAD_BEEF, 7'd0, 1'b0);
    send_word(32'hA5A5_0304, 7'd1, 1'b0);
    send(csum ^ 8'h5A, 1'b0);
    check("s2_error", 32'(error), 32'd1);
    check("s2_done", 32'(done), 32'd0);
    check("s2_cpu_hold", 32'(cpu_hold), 32'd1);
    check("s2_writes", 32'(wr_count - base), 32'd2);

    // Count 0 means the whole memory: 128 words, addresses 0..127.
    base = wr_count;
    frame_start(8'h00, 1'b0);
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      send_word(w, AW'(i), 1'b0);
    end
    check("s3_writes", 32'(wr_count - base), 32'd128);
    check("s3_check_done", 32'(done), 32'd0);
    check("s3_check_error", 32'(error), 32'd0);
    check("s3_check_hold", 32'(cpu_hold), 32'd1);
    send(csum, 1'b0);
    check("s3_done", 32'(done), 32'd1);
    check("s3_cpu_hold", 32'(cpu_hold), 32'd0);

    // Stall after two payload bytes.
    base = wr_count;
    frame_start(8'h01, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    repeat (TO - 1) tick();
    check("s4_error_before_limit", 32'(error), 32'd0);
    tick();
    check("s4_error_at_limit", 32'(error), 32'd1);
    check("s4_cpu_hold", 32'(cpu_hold), 32'd1);
    check("s4_writes", 32'(wr_count - base), 32'd0);

    // Reset after three payload bytes, then a fresh frame.
    base = wr_count;
    frame_start(8'h01, 1'b0);
    send(8'h78, 1'b0);
    send(8'h56, 1'b0);
    send(8'h34, 1'b0);
    rst = 1'b1;
    tick();
    check("s5_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("s5_rst_im_we", 32'(bus.im_we), 32'd0);
    check("s5_rst_im_addr", 32'(bus.im_addr), 32'd0);
    check("s5_rst_im_wdata", bus.im_wdata, 32'd0);
    check("s5_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("s5_rst_done", 32'(done), 32'd0);
    check("s5_rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    tick();
    check("s5_partial_writes", 32'(wr_count - base), 32'd0);
    basic_frame(1'b0);
    check("s5_done", 32'(done), 32'd1);
    check("s5_cpu_hold", 32'(cpu_hold), 32'd0);
    check("s5_writes", 32'(wr_count - base), 32'd1);

    // Garbage before sync, rx_valid every other cycle.
    base = wr_count;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    check("s6_garbage_hold", 32'(cpu_hold), 32'd0);
    basic_frame(1'b1);
    check("s6_done", 32'(done), 32'd1);
    check("s6_cpu_hold", 32'(cpu_hold), 32'd0);
    check("s6_error", 32'(error), 32'd0);
    check("s6_writes", 32'(wr_count - base), 32'd1);

    repeat (2) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter IM_AWIDTH, default 7, is the instruction-memory word-address width (128 words, matching PC[8:2]).
REQ-002 Parameter TIMEOUT_CYC, default 50000, is the maximum idle cycles allowed between bytes inside a frame.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-005 Port rx_data, input, 8, is the incoming byte.
REQ-006 Port rx_valid, input, 1, indicates rx_data holds a byte.
REQ-007 Port rx_ready, output, 1, indicates the loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
REQ-008 Port im_we, output, 1, is the instruction-memory write strobe.
REQ-009 Port im_addr, output, IM_AWIDTH, is the instruction-memory word address.
REQ-010 Port im_wdata, output, 32, is the instruction word to write.
REQ-011 Port cpu_hold, output, 1, holds the CPU in reset while high (ORed into the CPU rst by the top level).
REQ-012 Port done, output, 1, indicates the last frame loaded with a good checksum.
REQ-013 Port error, output, 1, indicates the last frame failed on checksum or timeout.

Function
REQ-014 Frame format: sync 0xA5, count byte N (N=0 means 2^IM_AWIDTH words), 4N payload bytes little-endian per word, then checksum = XOR of all payload bytes.
REQ-015 The FSM SHALL have states IDLE, COUNT, DATA, CHECK, DONE and ERR.
REQ-016 rx_ready SHALL be 1 in every state except during reset.
REQ-017 In IDLE, DONE and ERR, an accepted byte 0xA5 moves to COUNT; other bytes are discarded with no state change.
REQ-018 Entering COUNT sets cpu_hold=1, clears done/error/checksum/byte index, and sets the word index to 0.
REQ-019 In COUNT, the accepted byte loads the word counter (0 loads 2^IM_AWIDTH), then the FSM moves to DATA.
REQ-020 In DATA, byte k (k=0..3) of a word goes to bits [8k+7:8k]; each payload byte is XORed into the checksum.
REQ-021 Acceptance of byte 3 SHALL produce, in the next cycle only, im_we=1 with im_addr=word index and im_wdata=assembled word.
REQ-022 After that write, the word index increments; when the word count is exhausted, the FSM moves to CHECK.
REQ-023 In CHECK, an accepted byte equal to the checksum moves to DONE (done=1, cpu_hold=0); any other value moves to ERR (error=1, cpu_hold stays 1).
REQ-024 In COUNT, DATA or CHECK, TIMEOUT_CYC consecutive cycles without a transfer SHALL move the FSM to ERR; the partial word is not written.
REQ-025 A word index of 2^IM_AWIDTH-1 is the last valid address; the index SHALL never wrap within a frame.
REQ-026 A byte 0xA5 arriving inside DATA/CHECK is treated as data, not as resync.
REQ-027 im_we SHALL be low in every cycle except those given in REQ-021.

Reset
REQ-028 On rst, the FSM goes to IDLE and im_we, im_addr, im_wdata, cpu_hold, done, error, counters and checksum all go to 0.
REQ-029 Reset mid-frame SHALL abandon the frame, and a partially assembled word SHALL never be written.
REQ-030 During rst, rx_ready SHALL be 0.

Structure
REQ-031 The shared package SHALL hold: SYNC_BYTE=8'hA5, the FSM state enum, and the IM_AWIDTH default.
REQ-032 The idle-timeout counter SHALL be a separate sub-module, loader_timeout (clear, enable, expired outputs); all other logic is flat.

Verification
REQ-033 The bench SHALL cover: A5,01,78,56,34,12,checksum 08 -> one im_we pulse with addr 0 and data 0x12345678, then done=1 and cpu_hold=0.
REQ-034 The bench SHALL cover: A5,02, two words, wrong checksum -> two writes (addr 0, addr 1), then error=1 and cpu_hold=1.
REQ-035 The bench SHALL cover: A5,00, then 512 bytes -> 128 writes at addr 0..127, no wrap, then CHECK.
REQ-036 The bench SHALL cover: A5,01,two bytes, then idle for TIMEOUT_CYC cycles -> error=1 and no im_we.
REQ-037 The bench SHALL cover: rst after 3 payload bytes -> all outputs 0 and no write; a fresh frame then loads correctly.
REQ-038 The bench SHALL cover: garbage bytes 00,FF before A5, with rx_valid toggled every other cycle -> garbage ignored and the result is identical to REQ-033.
